pipeline_sequencer: RTL and testbench

Central stall/flush scheduler for the 5-stage RISC-V pipeline. It collects hazard and resource requests: load-use bubble from the hazard detector, taken branch/jump from EX, multi-cycle data-memory access, and ECALL I/O wait. It resolves them by fixed priority and drives the per-stage pipeline-register enables and flushes. It also keeps a saturating stall-cycle counter for debug display.

---
 rtl/pipeline_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//
// Central stall/flush scheduler for the 5-stage RISC-V pipeline. It collects
// hazard and resource requests and resolves them by fixed priority:
//   1. multi-cycle data-memory access   (freeze the whole pipe)
//   2. ECALL waiting for user I/O       (freeze the whole pipe)
//   3. taken branch / jump from EX      (flush IF/ID and ID/EX)
//   4. load-use hazard                  (hold PC and IF/ID, bubble into ID/EX)
// It drives the per-stage pipeline-register enables and flushes, and keeps a
// saturating count of cycles in which the PC was held, for debug display.
//
// Parameters:
//   MEM_LAT  data-memory access latency in freeze cycles (0 = never freezes)
//   CNT_W    width of the stall_cycles counter
//
// Ports:
//   clk           system clock, all state updates on posedge
//   rst           synchronous, active-low reset
//   load_use      hazard detector requests one bubble
//   branch_taken  EX resolved a taken branch/JAL/JALR this cycle
//   mem_req       MEM stage holds a valid load/store
//   ecall_ex      ECALL instruction currently in EX
//   io_continue   user confirm button (level, debounced)
//   pc_en         PC register write enable
//   if_id_en      IF/ID register enable
//   id_ex_en      ID/EX register enable
//   ex_mem_en     EX/MEM register enable
//   mem_wb_en     MEM/WB register enable
//   if_id_flush   load NOP into IF/ID
//   id_ex_flush   load NOP into ID/EX
//   state         current FSM state (0 RUN, 1 MEM_WAIT, 2 ECALL_WAIT)
//   stall_cycles  saturating count of cycles with pc_en=0
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             ecall_ex,
    input  logic             io_continue,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_ECALL_WAIT = 2'd2
    } state_t;

    // The wait counter holds the number of MEM_WAIT cycles still to spend,
    // including the current one. The request cycle itself is the first of
    // the MEM_LAT frozen cycles, so MEM_WAIT lasts MEM_LAT-1 cycles.
    localparam int             CW        = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]  WAIT_LOAD = CW'((MEM_LAT > 1) ? MEM_LAT - 1 : 0);
    localparam logic [CW-1:0]  WAIT_LAST = CW'(1);

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           mem_served_q, mem_served_d;
    logic           ecall_served_q, ecall_served_d;
    logic           cont_prev_q;

    logic           in_run;
    logic           mem_freeze;
    logic           ecall_freeze;
    logic           cont_rise;

    // ------------------------------------------------------------------
    // Request decode (RUN state only)
    // ------------------------------------------------------------------
    assign in_run       = (state_q == ST_RUN);
    // mem_served masks the access that has just been waited for, so the
    // same instruction still sitting in MEM does not freeze a second time.
    assign mem_freeze   = in_run && mem_req && !mem_served_q && (MEM_LAT > 0);
    assign ecall_freeze = in_run && !mem_freeze && ecall_ex && !ecall_served_q;
    assign cont_rise    = io_continue && !cont_prev_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of all the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            mem_served_q   <= 1'b0;
            ecall_served_q <= 1'b0;
            // A button held through reset must not look like a fresh press.
            cont_prev_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_served_q   <= mem_served_d;
            ecall_served_q <= ecall_served_d;
            cont_prev_q    <= io_continue;
        end
    end

    // ------------------------------------------------------------------
    // Debug stall counter: saturates instead of wrapping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_served_d   = mem_served_q;
        ecall_served_d = ecall_served_q;

        case (state_q)
            ST_RUN: begin
                if (mem_freeze) begin
                    if (MEM_LAT > 1) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        // One-cycle freeze: the request cycle is the whole wait.
                        mem_served_d = 1'b1;
                    end
                end else if (ecall_freeze) begin
                    state_d = ST_ECALL_WAIT;
                end else begin
                    // The served access leaves MEM once EX/MEM advances.
                    if (ex_mem_en) begin
                        mem_served_d = 1'b0;
                    end
                    // The served ECALL leaves EX once ID/EX loads a real
                    // instruction behind it (not a bubble or a flush).
                    if (id_ex_en && !if_id_flush && !id_ex_flush) begin
                        ecall_served_d = 1'b0;
                    end
                end
            end

            ST_MEM_WAIT: begin
                if ((wait_cnt_q == WAIT_LAST) || (wait_cnt_q == '0)) begin
                    state_d      = ST_RUN;
                    mem_served_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_LAST;
                end
            end

            ST_ECALL_WAIT: begin
                if (cont_rise) begin
                    state_d        = ST_RUN;
                    ecall_served_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: combinational from registered state and current inputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (rst && in_run && !mem_freeze && !ecall_freeze) begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (branch_taken) begin
                // The redirect squashes the load-use dependent, so any
                // simultaneous load_use bubble is unnecessary.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
//
// Two sequencers share one stimulus: MEM_LAT=2/CNT_W=16 and MEM_LAT=4/CNT_W=4
// (the narrow counter reaches saturation). Each is compared every cycle with
// a behavioural model that tracks remaining freeze cycles, an ECALL-waiting
// flag and the served flags, plus directed scenarios with fixed expectations.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic load_use, branch_taken, mem_req, ecall_ex, io_continue;

    logic [1:0]  pc_en_v, if_id_en_v, id_ex_en_v, ex_mem_en_v, mem_wb_en_v;
    logic [1:0]  if_id_flush_v, id_ex_flush_v;
    logic [1:0]  state2, state4;
    logic [15:0] stall2;
    logic [3:0]  stall4;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;

    localparam logic [6:0] C_ALL  = 7'b1111100;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_LU   = 7'b0011101;
    localparam logic [6:0] C_NONE = 7'b0000000;

    always #5 clk = ~clk;

    pipeline_sequencer #(.MEM_LAT(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
        .mem_req(mem_req), .ecall_ex(ecall_ex), .io_continue(io_continue),
        .pc_en(pc_en_v[0]), .if_id_en(if_id_en_v[0]), .id_ex_en(id_ex_en_v[0]),
        .ex_mem_en(ex_mem_en_v[0]), .mem_wb_en(mem_wb_en_v[0]),
        .if_id_flush(if_id_flush_v[0]), .id_ex_flush(id_ex_flush_v[0]),
        .state(state2), .stall_cycles(stall2)
    );

    pipeline_sequencer #(.MEM_LAT(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .load_use(load_use), .branch_taken(branch_taken),
        .mem_req(mem_req), .ecall_ex(ecall_ex), .io_continue(io_continue),
        .pc_en(pc_en_v[1]), .if_id_en(if_id_en_v[1]), .id_ex_en(id_ex_en_v[1]),
        .ex_mem_en(ex_mem_en_v[1]), .mem_wb_en(mem_wb_en_v[1]),
        .if_id_flush(if_id_flush_v[1]), .id_ex_flush(id_ex_flush_v[1]),
        .state(state4), .stall_cycles(stall4)
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    function automatic logic [6:0] ctrl_of(input int i);
        return {pc_en_v[i], if_id_en_v[i], id_ex_en_v[i], ex_mem_en_v[i],
                mem_wb_en_v[i], if_id_flush_v[i], id_ex_flush_v[i]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycle, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    typedef struct {
        int mem_left;     // frozen MEM_WAIT cycles still ahead
        bit ecall_wait;   // waiting for the user button
        bit mem_served;
        bit ecall_served;
        bit cont_prev;
        int stall;
    } model_t;

    model_t m [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.mem_left = 0; r.ecall_wait = 0; r.mem_served = 0;
        r.ecall_served = 0; r.cont_prev = 1; r.stall = 0;
        return r;
    endfunction

    function automatic logic [6:0] model_ctrl(input model_t s, input int lat);
        if (!rst)                                 return C_NONE;
        if (s.mem_left > 0 || s.ecall_wait)       return C_NONE;
        if (mem_req && !s.mem_served && lat > 0)  return C_NONE;
        if (ecall_ex && !s.ecall_served)          return C_NONE;
        if (branch_taken)                         return C_BR;
        if (load_use)                             return C_LU;
        return C_ALL;
    endfunction

    function automatic logic [1:0] model_state(input model_t s);
        if (s.mem_left > 0) return 2'd1;
        if (s.ecall_wait)   return 2'd2;
        return 2'd0;
    endfunction

    function automatic model_t model_step(input model_t s, input int lat, input int maxv);
        model_t n = s;
        logic [6:0] c = model_ctrl(s, lat);
        if (!rst) return model_reset();
        if (!c[6] && s.stall < maxv) n.stall = s.stall + 1;
        n.cont_prev = io_continue;
        if (s.mem_left > 0) begin
            n.mem_left = s.mem_left - 1;
            if (n.mem_left == 0) n.mem_served = 1;
        end else if (s.ecall_wait) begin
            if (io_continue && !s.cont_prev) begin
                n.ecall_wait   = 0;
                n.ecall_served = 1;
            end
        end else if (mem_req && !s.mem_served && lat > 0) begin
            n.mem_left = lat - 1;
            if (lat == 1) n.mem_served = 1;
        end else if (ecall_ex && !s.ecall_served) begin
            n.ecall_wait = 1;
        end else begin
            if (c[3]) n.mem_served = 0;
            if (c[4] && c[1:0] == 2'b00) n.ecall_served = 0;
        end
        return n;
    endfunction

    // One clock: compare both DUTs at negedge, advance models at posedge.
    task automatic tick();
        @(negedge clk);
        check("ctrl_lat2",  32'(ctrl_of(0)), 32'(model_ctrl(m[0], lat_of(0))));
        check("ctrl_lat4",  32'(ctrl_of(1)), 32'(model_ctrl(m[1], lat_of(1))));
        check("state_lat2", 32'(state2), 32'(model_state(m[0])));
        check("state_lat4", 32'(state4), 32'(model_state(m[1])));
        check("stall_lat2", 32'(stall2), 32'(m[0].stall));
        check("stall_lat4", 32'(stall4), 32'(m[1].stall));
        @(posedge clk);
        for (int i = 0; i < 2; i++) m[i] = model_step(m[i], lat_of(i), max_of(i));
        #1;
        cycle++;
    endtask

    task automatic clear_inputs();
        load_use = 0; branch_taken = 0; mem_req = 0; ecall_ex = 0; io_continue = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        rst = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) m[i] = model_reset();

        // Reset with the button held: no enables, no count, no false edge.
        io_continue = 1;
        tick();
        #2;
        check("rst_ctrl", 32'(ctrl_of(0)), 32'(C_NONE));
        check("rst_stall", 32'(stall2), 32'd0);
        tick();
        rst = 1;
        #2;
        check("post_rst_ctrl", 32'(ctrl_of(0)), 32'(C_ALL));
        check("post_rst_state", 32'(state2), 32'd0);
        ecall_ex = 1;
        tick();
        ecall_ex = 0;
        repeat (3) tick();
        #2;
        check("held_btn_no_exit", 32'(state2), 32'd2);
        io_continue = 0;
        tick();
        io_continue = 1;
        tick();
        io_continue = 0;
        #2;
        check("btn_edge_exit", 32'(state2), 32'd0);
        tick();

        // Load-use bubble.
        do_reset();
        load_use = 1;
        #2;
        check("lu_ctrl", 32'(ctrl_of(0)), 32'(C_LU));
        tick();
        load_use = 0;
        #2;
        check("lu_after_ctrl", 32'(ctrl_of(0)), 32'(C_ALL));
        check("lu_stall", 32'(stall2), 32'd1);
        tick();

        // Branch beats load-use.
        do_reset();
        load_use = 1; branch_taken = 1;
        #2;
        check("br_lu_ctrl", 32'(ctrl_of(0)), 32'(C_BR));
        tick();
        clear_inputs();
        #2;
        check("br_lu_stall", 32'(stall2), 32'd0);
        tick();

        // Memory freeze with mem_req held (MEM_LAT=2 instance).
        do_reset();
        mem_req = 1;
        #2;
        check("mem_f0_ctrl", 32'(ctrl_of(0)), 32'(C_NONE));
        check("mem_f0_state", 32'(state2), 32'd0);
        tick();
        #2;
        check("mem_f1_ctrl", 32'(ctrl_of(0)), 32'(C_NONE));
        check("mem_f1_state", 32'(state2), 32'd1);
        tick();
        #2;
        check("mem_release", 32'(ctrl_of(0)), 32'(C_ALL));
        tick();
        #2;
        check("mem_refreeze", 32'(ctrl_of(0)), 32'(C_NONE));
        repeat (4) tick();
        mem_req = 0;
        repeat (2) tick();

        // ECALL wait released by a button pulse.
        do_reset();
        ecall_ex = 1;
        for (int k = 0; k < 10; k++) begin
            #2;
            check("ecall_frozen", 32'(ctrl_of(0)), 32'(C_NONE));
            tick();
        end
        io_continue = 1;
        tick();
        io_continue = 0;
        #2;
        check("ecall_exit_state", 32'(state2), 32'd0);
        check("ecall_no_reenter", 32'(ctrl_of(0)), 32'(C_ALL));
        check("ecall_stall", 32'(stall2), 32'd11);
        tick();
        ecall_ex = 0;
        tick();

        // Reset in the middle of a MEM_LAT=4 freeze.
        do_reset();
        mem_req = 1;
        tick();
        tick();
        #2;
        check("mid_wait_state4", 32'(state4), 32'd1);
        rst = 0;
        #1;
        check("mid_rst_ctrl4", 32'(ctrl_of(1)), 32'(C_NONE));
        tick();
        rst = 1; mem_req = 0;
        #2;
        check("mid_rst_state4", 32'(state4), 32'd0);
        check("mid_rst_stall4", 32'(stall4), 32'd0);
        check("mid_rst_ctrl4_run", 32'(ctrl_of(1)), 32'(C_ALL));
        tick();
        mem_req = 1;
        #2;
        check("mid_rst_served_clr", 32'(ctrl_of(1)), 32'(C_NONE));
        tick();
        mem_req = 0;
        repeat (4) tick();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 149) != 0);
            load_use     = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            ecall_ex     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) io_continue = ~io_continue;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
